vga_mem_arbiter: RTL and testbench

//  Shares one single-port, 1-cycle-read-latency video/data RAM between the CPU datapath and the VGA pixel fetcher.

---
 rtl/vga_arb_pkg.sv | 18 +
 rtl/vga_arb_stats.sv | 25 ++
 rtl/vga_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_vga_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA/CPU memory arbiter.
//   owner_t    : which requester issued the read currently in flight
//   ADDR_W_DEF : default memory address width
//   DATA_W_DEF : default memory data width
//   STAT_W     : width of the stall statistics counter
package vga_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned STAT_W     = 16;

endpackage

// File: rtl/vga_arb_stats.sv
// Saturating event counter used for CPU stall statistics.
//   clk   in  : system clock
//   reset in  : asynchronous active-high reset, clears the count
//   inc   in  : count this cycle
//   count out : current count, sticks at all-ones
module vga_arb_stats
  import vga_arb_pkg::*;
#(
  parameter int unsigned W = STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Arbiter sharing one single-port, 1-cycle-latency RAM between the VGA pixel
// fetcher and the CPU. VGA has priority while bright=1, limited by a
// starvation counter; the CPU has priority during blanking; an urgent VGA
// request always wins. Read data is steered back to the requester that owned
// the issuing cycle.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   bright                        : 1 = visible region, 0 = blanking
//   vga_req/urgent/addr           : VGA read request
//   vga_gnt/rvalid/rdata          : VGA grant and returned data
//   cpu_req/we/addr/wdata         : CPU read/write request
//   cpu_stall/rvalid/rdata        : CPU stall and returned data
//   mem_en/we/addr/wdata, mem_rdata : RAM interface
//   stat_stall                    : CPU stall-cycle count
// Build option: define VGA_ARB_STATS_EN to build the stall counter; otherwise
// stat_stall is tied to zero.
module vga_mem_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bright,
  input  logic              vga_req,
  input  logic              vga_urgent,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_stall
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]  starve_cnt;
  owner_t            rd_owner;
  logic              gnt_cpu;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] vga_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  // Grants are gated by reset so every output reads zero while it is held.
  always_comb begin
    vga_gnt = 1'b0;
    gnt_cpu = 1'b0;
    if (!reset) begin
      if (vga_req && vga_urgent)                            vga_gnt = 1'b1;
      else if (!bright && cpu_req)                          gnt_cpu = 1'b1;
      else if (cpu_req && starve_cnt == CNT_W'(STARVE_MAX)) gnt_cpu = 1'b1;
      else if (vga_req)                                     vga_gnt = 1'b1;
      else if (cpu_req)                                     gnt_cpu = 1'b1;
    end
  end

  // Address/write data hold their last issued value on idle cycles.
  always_comb begin
    mem_en    = vga_gnt | gnt_cpu;
    mem_we    = gnt_cpu & cpu_we;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (vga_gnt) begin
      mem_addr = vga_addr;
    end else if (gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign cpu_stall  = cpu_req & ~gnt_cpu & ~reset;
  assign vga_rvalid = (rd_owner == OWN_VGA);
  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt  <= '0;
      rd_owner    <= OWN_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (gnt_cpu || !cpu_req) begin
        starve_cnt <= '0;
      end else if (vga_gnt && starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (vga_gnt)                  rd_owner <= OWN_VGA;
      else if (gnt_cpu && !cpu_we)  rd_owner <= OWN_CPU;
      else                          rd_owner <= OWN_NONE;

      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (vga_rvalid) vga_rdata_q <= mem_rdata;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
    end
  end

`ifdef VGA_ARB_STATS_EN
  vga_arb_stats #(.W(STAT_W)) u_stats (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_stall),
    .count (stat_stall)
  );
`else
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed self-checking bench for vga_mem_arbiter. The RAM model returns
// addr ^ 16'h5A5A one cycle after a read and 16'hDEAD after any other cycle,
// so held read data can be told apart from fresh data.
module tb_vga_mem_arbiter;
  import vga_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        bright, vga_req, vga_urgent, cpu_req, cpu_we;
  logic [15:0] vga_addr, cpu_addr, cpu_wdata;
  logic        vga_gnt, vga_rvalid, cpu_stall, cpu_rvalid;
  logic [15:0] vga_rdata, cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] stat_stall;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bright     (bright),
    .vga_req    (vga_req),
    .vga_urgent (vga_urgent),
    .vga_addr   (vga_addr),
    .vga_gnt    (vga_gnt),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stat_stall (stat_stall)
  );

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr ^ 16'h5A5A;
    else                   mem_rdata <= 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic vr, input logic vu, input logic [15:0] va,
                       input logic cr, input logic cw, input logic [15:0] ca,
                       input logic [15:0] cd);
    bright = b; vga_req = vr; vga_urgent = vu; vga_addr = va;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {vga_gnt, vga_rvalid, cpu_stall, cpu_rvalid, mem_en, mem_we}, 0);
    check({tag, "_rdata"}, {vga_rdata, cpu_rdata}, 0);
    check({tag, "_mem"}, {mem_addr, mem_wdata}, 0);
    check({tag, "_stat"}, stat_stall, 0);
  endtask

  initial begin
    reset = 1'b1;
    mem_rdata = 16'h0;
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // 1: VGA streams in the visible region; CPU read wins after 4 VGA grants.
    cyc();
    drive(1, 1, 0, 16'h2000, 1, 0, 16'h0040, 16'h0);
    for (int i = 0; i < 4; i++) begin
      check("t1_vga_gnt", {vga_gnt, cpu_stall, mem_en, mem_we}, 4'b1110);
      check("t1_vga_addr", mem_addr, 16'h2000);
      if (i > 0) check("t1_vga_rd", {vga_rvalid, vga_rdata}, {1'b1, 16'h7A5A});
      cyc();
    end
    check("t1_cpu_gnt", {vga_gnt, cpu_stall, mem_en, mem_we}, 4'b0010);
    check("t1_cpu_addr", mem_addr, 16'h0040);
    cyc();
    drive(1, 0, 0, 16'h2000, 0, 0, 16'h0040, 16'h0);
    check("t1_cpu_rd", {cpu_rvalid, vga_rvalid, cpu_rdata}, {2'b10, 16'h5A1A});
`ifdef VGA_ARB_STATS_EN
    check("t1_stat", stat_stall, 16'd4);
`else
    check("t1_stat", stat_stall, 16'd0);
`endif

    // 2: blanking, both non-urgent -> CPU first, VGA next.
    cyc();
    drive(0, 1, 0, 16'h2000, 1, 0, 16'h0010, 16'h0);
    check("t2_cpu_first", {vga_gnt, cpu_stall, mem_en}, 3'b001);
    check("t2_cpu_addr", mem_addr, 16'h0010);
    cyc();
    drive(0, 1, 0, 16'h2000, 0, 0, 16'h0010, 16'h0);
    check("t2_vga_next", {vga_gnt, mem_addr}, {1'b1, 16'h2000});
    check("t2_cpu_rd", {cpu_rvalid, cpu_rdata}, {1'b1, 16'h5A4A});
    cyc();
    drive(0, 0, 0, 16'h2000, 0, 0, 16'h0010, 16'h0);
    check("t2_vga_rd", {vga_rvalid, cpu_rvalid, mem_en, vga_rdata}, {3'b100, 16'h7A5A});
    check("t2_cpu_hold", cpu_rdata, 16'h5A4A);

    // 3: urgent VGA beats a blanking CPU write; write issues next cycle.
    cyc();
    drive(0, 1, 1, 16'h2000, 1, 1, 16'h0100, 16'hBEEF);
    check("t3_urgent", {vga_gnt, cpu_stall, mem_we}, 3'b110);
    cyc();
    drive(0, 0, 0, 16'h2000, 1, 1, 16'h0100, 16'hBEEF);
    check("t3_write", {mem_en, mem_we, cpu_stall, vga_gnt}, 4'b1100);
    check("t3_write_bus", {mem_addr, mem_wdata}, {16'h0100, 16'hBEEF});
    cyc();
    drive(0, 0, 0, 16'h2000, 0, 0, 16'h0100, 16'hBEEF);
    check("t3_no_rvalid", {cpu_rvalid, mem_en, mem_we}, 3'b000);
    check("t3_bus_hold", {mem_addr, mem_wdata}, {16'h0100, 16'hBEEF});

    // 4: alternate VGA / CPU reads back to back.
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k % 2 == 0) begin
        drive(1, 1, 0, 16'h2000, 0, 0, 16'h0010, 16'h0);
        check("t4_vga_gnt", {vga_gnt, mem_en, mem_addr}, {2'b11, 16'h2000});
        if (k > 0) check("t4_cpu_rd", {cpu_rvalid, vga_rvalid, cpu_rdata}, {2'b10, 16'h5A4A});
        else       check("t4_idle_rv", {cpu_rvalid, vga_rvalid}, 2'b00);
      end else begin
        drive(1, 0, 0, 16'h2000, 1, 0, 16'h0010, 16'h0);
        check("t4_cpu_gnt", {vga_gnt, cpu_stall, mem_en, mem_addr}, {3'b001, 16'h0010});
        check("t4_vga_rd", {vga_rvalid, cpu_rvalid, vga_rdata}, {2'b10, 16'h7A5A});
      end
      check("t4_both_rv", vga_rvalid & cpu_rvalid, 0);
    end
    cyc();
    drive(1, 0, 0, 16'h2000, 0, 0, 16'h0010, 16'h0);
    check("t4_last_rd", {cpu_rvalid, vga_rvalid, cpu_rdata}, {2'b10, 16'h5A4A});

    // 5a: reset with starve_cnt saturated and a VGA read in flight.
    cyc();
    drive(1, 1, 0, 16'h3000, 1, 0, 16'h0040, 16'h0);
    for (int i = 0; i < 4; i++) begin
      check("t5_pre_vga", vga_gnt, 1);
      cyc();
    end
    reset = 1'b1;
    #1;
    check("t5_rst_drop", {vga_rvalid, cpu_rvalid, mem_en, cpu_stall}, 4'b0000);
    cyc();
    reset = 1'b0;
    #1;
    // starve_cnt must be back at 0: four VGA grants again before the CPU.
    for (int i = 0; i < 4; i++) begin
      check("t5_post_vga", {vga_gnt, cpu_stall}, 2'b11);
      cyc();
    end
    check("t5_post_cpu", {vga_gnt, cpu_stall, mem_en, mem_addr}, {3'b001, 16'h0040});
    // 5b: reset the cycle after that CPU read grant.
    cyc();
    reset = 1'b1;
    drive(1, 0, 0, 16'h3000, 0, 0, 16'h0040, 16'h0);
    check_all_zero("t5_rst");
    cyc();
    check_all_zero("t5_rst_hold");
    reset = 1'b0;
    cyc();
    drive(0, 1, 0, 16'h3000, 1, 0, 16'h0040, 16'h0);
    check("t5_first_gnt", {vga_gnt, cpu_stall, mem_en, mem_addr}, {3'b001, 16'h0040});

    // 6: long stall run for the statistics counter.
    cyc();
    drive(1, 1, 1, 16'h3000, 1, 0, 16'h0040, 16'h0);
    check("t6_stall", cpu_stall, 1);
`ifdef VGA_ARB_STATS_EN
    repeat (70000) cyc();
    check("t6_stat_sat", stat_stall, 16'hFFFF);
`else
    repeat (50) cyc();
    check("t6_stat_off", stat_stall, 16'h0000);
`endif
    drive(0, 0, 0, 16'h0, 0, 0, 16'h0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
